// File: rtl/mc_block_xfer_if.sv
// mc_block_xfer_if: request/response port toward mem_arb plus the host memory-controller bus.
// slave = the block converter, master = its environment (arbiter and host side).
interface mc_block_xfer_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BLK_BITS  = 512
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [31:0]          req_addr;
  logic [BLK_BITS-1:0]  req_blk;
  logic                 rsp_valid;
  logic [BLK_BITS-1:0]  rsp_blk;
  logic                 wr_done;
  logic                 err;
  logic [2:0]           op;
  logic [31:0]          io_addr;
  logic [WORD_SIZE-1:0] common_data_bus_out;
  logic [WORD_SIZE-1:0] common_data_bus_in;
  logic                 tx_done;
  logic                 rd_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_blk,
    input  common_data_bus_in, tx_done, rd_valid,
    output req_ready, rsp_valid, rsp_blk, wr_done, err,
    output op, io_addr, common_data_bus_out
  );

  modport master (
    output req_valid, req_write, req_addr, req_blk,
    output common_data_bus_in, tx_done, rd_valid,
    input  req_ready, rsp_valid, rsp_blk, wr_done, err,
    input  op, io_addr, common_data_bus_out
  );
endinterface

// File: rtl/mc_block_xfer.sv
// mc_block_xfer: serialises block writes into WORD_SIZE-bit host beats and gathers read beats into a block.
// Define MC_XFER_TIMEOUT_EN to add an idle-beat watchdog that aborts a stalled transfer with an err pulse.
module mc_block_xfer #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BLK_BITS  = 512
`ifdef MC_XFER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic           clk,
  input  logic           rst,
  mc_block_xfer_if.slave bus
);

  localparam int unsigned BEATS = BLK_BITS / WORD_SIZE;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]          io_addr_q, io_addr_d;
  logic [BLK_BITS-1:0]  blk_q, blk_d;
  logic [BLK_BITS-1:0]  rsp_blk_q, rsp_blk_d;
  logic [WORD_SIZE-1:0] bus_out_q, bus_out_d;
  logic [2:0]           op_q, op_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 wr_done_q, wr_done_d;
  logic                 err_q, err_d;

  logic accept_c, rd_beat_c, wr_beat_c, last_beat_c, timeout_c;
  logic unused_addr_bits;

  assign accept_c    = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign rd_beat_c   = (state_q == RD) && bus.rd_valid;
  assign wr_beat_c   = (state_q == WR) && bus.tx_done;
  assign last_beat_c = (beat_cnt_q == LAST_BEAT);
  assign unused_addr_bits = ^bus.req_addr[5:0];

`ifdef MC_XFER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counts consecutive beat-less cycles while a transfer is in flight.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_c = 1'b0;
    if ((state_q == RD && !rd_beat_c) || (state_q == WR && !wr_beat_c)) begin
      wd_cnt_d  = wd_cnt_q + WD_W'(1);
      timeout_c = (wd_cnt_d == WD_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_cnt_q <= '0;
    else      wd_cnt_q <= wd_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept_c) state_d = bus.req_write ? WR : RD;
      RD: begin
        if (timeout_c)                     state_d = IDLE;
        else if (rd_beat_c && last_beat_c) state_d = DONE;
      end
      WR: begin
        if (timeout_c)                     state_d = IDLE;
        else if (wr_beat_c && last_beat_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    req_ready_d = 1'b0;
    op_d        = OP_NOP;
    unique case (state_d)
      IDLE:    req_ready_d = 1'b1;
      RD:      op_d = OP_READ;
      WR:      op_d = OP_WRITE;
      default: ;
    endcase
    rsp_valid_d = (state_q == RD) && (state_d == DONE);
    wr_done_d   = (state_q == WR) && (state_d == DONE);
    err_d       = timeout_c;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    io_addr_d  = io_addr_q;
    blk_d      = blk_q;
    rsp_blk_d  = rsp_blk_q;
    if (accept_c) begin
      beat_cnt_d = '0;
      io_addr_d  = {bus.req_addr[31:6], 6'b0};
      blk_d      = bus.req_blk;
    end
    if (rd_beat_c) begin
      rsp_blk_d[32'(beat_cnt_q) * WORD_SIZE +: WORD_SIZE] = bus.common_data_bus_in;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (wr_beat_c) beat_cnt_d = beat_cnt_q + CNT_W'(1);
    if (timeout_c) beat_cnt_d = '0;
    bus_out_d = (state_d == WR) ? blk_d[32'(beat_cnt_d) * WORD_SIZE +: WORD_SIZE] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q  <= '0;
      io_addr_q   <= '0;
      blk_q       <= '0;
      rsp_blk_q   <= '0;
      bus_out_q   <= '0;
      op_q        <= OP_NOP;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      io_addr_q   <= io_addr_d;
      blk_q       <= blk_d;
      rsp_blk_q   <= rsp_blk_d;
      bus_out_q   <= bus_out_d;
      op_q        <= op_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready           = req_ready_q;
  assign bus.rsp_valid           = rsp_valid_q;
  assign bus.rsp_blk             = rsp_blk_q;
  assign bus.wr_done             = wr_done_q;
  assign bus.err                 = err_q;
  assign bus.op                  = op_q;
  assign bus.io_addr             = io_addr_q;
  assign bus.common_data_bus_out = bus_out_q;

endmodule
